freq_sweep_ctrl: RTL and testbench

//  Sequencer for the freq_gen clock divider. It drives freq_gen's freq_sel and rst inputs.
//  It sweeps freq_sel from a programmed start value to a programmed stop value in fixed steps.

---
 rtl/freq_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps freq_gen's freq_sel from a start value to a stop value,
// holding each value for a number of clk_out rising edges (clk_out sampled as data).
// Ports: clk_in/rst_n; start/abort control; sel_start/sel_stop/sel_step/dwell
// config; clk_out feedback; freq_sel/gen_rst (registered), busy/step_pulse/done.
module freq_sweep_ctrl #(
  parameter int DataWidth  = 8,
  parameter int DwellWidth = 16,
  parameter logic [DataWidth-1:0] ResetSel = DataWidth'(8)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DataWidth-1:0]  sel_start,
  input  logic [DataWidth-1:0]  sel_stop,
  input  logic [DataWidth-1:0]  sel_step,
  input  logic [DwellWidth-1:0] dwell,
  input  logic                  clk_out,
  output logic [DataWidth-1:0]  freq_sel,
  output logic                  gen_rst,
  output logic                  busy,
  output logic                  step_pulse,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  freq_sel_q, freq_sel_d;
  logic                  gen_rst_q, gen_rst_d;
  logic                  clk_out_q;
  logic [DwellWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0]  start_l_q, start_l_d;
  logic [DataWidth-1:0]  stop_l_q, stop_l_d;
  logic [DataWidth-1:0]  step_l_q, step_l_d;
  logic [DwellWidth-1:0] dwell_l_q, dwell_l_d;
  logic                  dir_up_q, dir_up_d;

  logic                  edge_w;
  logic [DwellWidth-1:0] dwell_eff;
  logic [DwellWidth-1:0] cnt_inc;
  logic [DataWidth:0]    sum_w;
  logic [DataWidth:0]    dif_w;
  logic                  clamp_w;
  logic [DataWidth-1:0]  nxt_w;

  assign edge_w    = clk_out & ~clk_out_q;
  assign dwell_eff = (dwell_l_q == '0) ? DwellWidth'(1) : dwell_l_q;
  assign cnt_inc   = cnt_q + DwellWidth'(1);

  // One extra bit catches wrap past either end of the range.
  assign sum_w = {1'b0, freq_sel_q} + {1'b0, step_l_q};
  assign dif_w = {1'b0, freq_sel_q} - {1'b0, step_l_q};

  always_comb begin
    clamp_w = 1'b0;
    nxt_w   = '0;
    if (dir_up_q) begin
      clamp_w = (sum_w > {1'b0, stop_l_q});
      nxt_w   = clamp_w ? stop_l_q : sum_w[DataWidth-1:0];
    end else begin
      clamp_w = dif_w[DataWidth] || (dif_w[DataWidth-1:0] < stop_l_q);
      nxt_w   = clamp_w ? stop_l_q : dif_w[DataWidth-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    freq_sel_d = freq_sel_q;
    gen_rst_d  = 1'b0;
    cnt_d      = cnt_q;
    start_l_d  = start_l_q;
    stop_l_d   = stop_l_q;
    step_l_d   = step_l_q;
    dwell_l_d  = dwell_l_q;
    dir_up_d   = dir_up_q;
    step_pulse = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          start_l_d = sel_start;
          stop_l_d  = sel_stop;
          step_l_d  = sel_step;
          dwell_l_d = dwell;
          dir_up_d  = (sel_start <= sel_stop);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          freq_sel_d = start_l_q;
          gen_rst_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (edge_w) begin
          cnt_d = cnt_inc;
          if (cnt_inc == dwell_eff) begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((step_l_q == '0) || (freq_sel_q == stop_l_q)) begin
          state_d = S_DONE;
        end else begin
          freq_sel_d = nxt_w;
          step_pulse = 1'b1;
          cnt_d      = '0;
          state_d    = S_DWELL;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      freq_sel_q <= ResetSel;
      gen_rst_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      cnt_q      <= '0;
      start_l_q  <= '0;
      stop_l_q   <= '0;
      step_l_q   <= '0;
      dwell_l_q  <= '0;
      dir_up_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_sel_q <= freq_sel_d;
      gen_rst_q  <= gen_rst_d;
      clk_out_q  <= clk_out;
      cnt_q      <= cnt_d;
      start_l_q  <= start_l_d;
      stop_l_q   <= stop_l_d;
      step_l_q   <= step_l_d;
      dwell_l_q  <= dwell_l_d;
      dir_up_q   <= dir_up_d;
    end
  end

  assign freq_sel = freq_sel_q;
  assign gen_rst  = gen_rst_q;
  assign busy     = (state_q == S_LOAD) || (state_q == S_DWELL)
                 || (state_q == S_STEP);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: sweep-list reference model with per-cycle compare,
// directed sweeps with literal sequences, abort, async reset and random sweeps.
module tb_freq_sweep_ctrl;

  localparam logic [7:0] RSEL = 8'h33;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  sel_start;
  logic [7:0]  sel_stop;
  logic [7:0]  sel_step;
  logic [15:0] dwell;
  logic        clk_out;
  logic [7:0]  freq_sel;
  logic        gen_rst;
  logic        busy;
  logic        step_pulse;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  freq_sweep_ctrl #(
    .DataWidth (8),
    .DwellWidth(16),
    .ResetSel  (RSEL)
  ) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .sel_start (sel_start),
    .sel_stop  (sel_stop),
    .sel_step  (sel_step),
    .dwell     (dwell),
    .clk_out   (clk_out),
    .freq_sel  (freq_sel),
    .gen_rst   (gen_rst),
    .busy      (busy),
    .step_pulse(step_pulse),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    clk_out = 1'b0;
    forever begin
      @(posedge clk);
      #1 clk_out = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is the list of values it visits; the bench
  // walks that list, counting edges per value, one cycle per load/step/done.
  int m_vals[$];
  int m_idx, m_edges, m_dw, m_sel;
  bit m_busy, m_ld, m_step, m_done, m_grst, m_prev, m_e;

  function automatic void build(int s, int e, int st);
    int v, n;
    m_vals.delete();
    v = s;
    m_vals.push_back(v);
    if (st != 0) begin
      while (v != e) begin
        if (s <= e) begin
          n = v + st;
          if (n > e) n = e;
        end else begin
          n = v - st;
          if (n < e) n = e;
        end
        v = n;
        m_vals.push_back(v);
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ld = 0; m_step = 0; m_done = 0;
      m_grst = 0; m_prev = 0; m_sel = int'(RSEL);
      m_idx = 0; m_edges = 0; m_dw = 1;
    end else begin
      m_e = clk_out && !m_prev;
      m_prev = clk_out;
      m_grst = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy && abort) begin
        m_busy = 0; m_ld = 0; m_step = 0;
      end else if (!m_busy) begin
        if (start && !abort) begin
          build(int'(sel_start), int'(sel_stop), int'(sel_step));
          m_dw = (dwell == 0) ? 1 : int'(dwell);
          m_busy = 1;
          m_ld = 1;
        end
      end else if (m_ld) begin
        m_ld = 0;
        m_idx = 0;
        m_sel = m_vals[0];
        m_edges = 0;
        m_grst = 1;
      end else if (m_step) begin
        m_step = 0;
        if (m_idx == m_vals.size() - 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_idx++;
          m_sel = m_vals[m_idx];
          m_edges = 0;
        end
      end else if (m_e) begin
        m_edges++;
        if (m_edges == m_dw) m_step = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("freq_sel", int'(freq_sel), m_sel);
      chk("gen_rst", int'(gen_rst), int'(m_grst));
      chk("busy", int'(busy), int'(m_busy));
      chk("step_pulse", int'(step_pulse),
          int'(m_step && !abort && (m_idx < m_vals.size() - 1)));
      chk("done", int'(done), int'(m_done));
    end
  end

  // Observed sweep: values seen after gen_rst and after each step_pulse.
  int rec[$];
  int n_grst, n_sp, n_done;
  bit sp_prev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (gen_rst) begin
        rec.push_back(int'(freq_sel));
        n_grst++;
      end
      if (sp_prev) rec.push_back(int'(freq_sel));
      sp_prev = step_pulse;
      if (step_pulse) n_sp++;
      if (done) n_done++;
    end
  end

  task automatic clear_rec();
    rec.delete();
    n_grst = 0; n_sp = 0; n_done = 0; sp_prev = 0;
  endtask

  task automatic chk_seq(string nm, int n, int a0, int a1, int a2, int a3);
    int a[4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    chk({nm, "_len"}, rec.size(), n);
    for (int k = 0; k < n && k < rec.size(); k++) chk(nm, rec[k], a[k]);
  endtask

  task automatic pulse_start(int s, int e, int st, int dw);
    @(posedge clk);
    #1;
    sel_start = 8'(s); sel_stop = 8'(e);
    sel_step = 8'(st); dwell = 16'(dw);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sel_start = 8'($urandom); sel_stop = 8'($urandom);
    sel_step = 8'($urandom); dwell = 16'($urandom);
  endtask

  task automatic wait_idle(int ab_pm, int st_pm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
      abort = ($urandom_range(0, 999) < ab_pm);
      start = ($urandom_range(0, 999) < st_pm);
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    if (!ok) chk("timeout_busy", 1, 0);
  endtask

  initial begin
    int s, e, st, dw;
    bit seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    sel_start = '0; sel_stop = '0; sel_step = '0; dwell = '0;
    clear_rec();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_freq_sel", int'(freq_sel), 8'h33);
    chk("rst_busy", int'(busy), 0);

    // Up sweep
    clear_rec();
    pulse_start(2, 8, 2, 3);
    wait_idle(0, 0);
    chk_seq("up_seq", 4, 2, 4, 6, 8);
    chk("up_grst", n_grst, 1);
    chk("up_steps", n_sp, 3);
    chk("up_done", n_done, 1);

    // Down sweep with clamp
    clear_rec();
    pulse_start(8, 2, 4, 2);
    wait_idle(0, 0);
    chk_seq("down_seq", 3, 8, 4, 2, 0);
    chk("down_done", n_done, 1);

    // Wrap guard
    clear_rec();
    pulse_start(250, 255, 10, 1);
    wait_idle(0, 0);
    chk_seq("wrap_seq", 2, 250, 255, 0, 0);
    chk("wrap_final", int'(freq_sel), 255);

    // Abort in dwell at 4, with a start pulse while busy
    clear_rec();
    pulse_start(2, 8, 2, 3);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (freq_sel == 8'd4) begin
        seen = 1;
        break;
      end
    end
    chk("abort_reach4", int'(seen), 1);
    @(posedge clk);
    #1;
    sel_start = 8'd100; sel_stop = 8'd200; sel_step = 8'd1; dwell = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sel", int'(freq_sel), 4);
    repeat (5) @(negedge clk);
    chk("abort_sel_hold", int'(freq_sel), 4);
    chk("abort_no_done", n_done, 0);
    chk("abort_steps", n_sp, 1);

    // Async reset mid-sweep
    pulse_start(2, 8, 2, 3);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_freq_sel", int'(freq_sel), 8'h33);
    chk("arst_busy", int'(busy), 0);
    chk("arst_gen_rst", int'(gen_rst), 0);
    chk("arst_step", int'(step_pulse), 0);
    chk("arst_done", int'(done), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_idle_busy", int'(busy), 0);
    chk("arst_idle_sel", int'(freq_sel), 8'h33);

    // Single point: step 0, dwell 0
    clear_rec();
    pulse_start(5, 9, 0, 0);
    wait_idle(0, 0);
    chk_seq("single_seq", 1, 5, 0, 0, 0);
    chk("single_steps", n_sp, 0);
    chk("single_done", n_done, 1);

    // Random sweeps with occasional abort and stray start
    for (int r = 0; r < 40; r++) begin
      s  = int'($urandom_range(0, 255));
      e  = int'($urandom_range(0, 255));
      st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(16, 255));
      dw = int'($urandom_range(0, 4));
      pulse_start(s, e, st, dw);
      wait_idle((r % 2 == 1) ? 8 : 0, 3);
    end
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
